// File: rtl/uart_rcvr.sv
// UART receiver: start-bit qualification, centre sampling of data and stop
// bits, and a host-side holding register with ready/overrun/framing flags.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | line idle, waiting for a low sample
//   STARTING  | line low, confirming the start bit up to its centre
//   RECEIVING | inside the frame, sampling data then stop at bit centres
module uart_rcvr #(
   parameter int word_size       = 8,
   parameter int Samples_per_bit = 8,
   parameter int Half_word       = Samples_per_bit / 2
) (
   input  logic                 Clock,
   input  logic                 rst_b,
   input  logic                 Serial_in,
   input  logic                 Read_ack,
   output logic [word_size-1:0] RCV_datareg,
   output logic                 Data_ready,
   output logic                 Error1,
   output logic                 Error2
);

   localparam int SW = $clog2(Samples_per_bit);
   localparam int BW = $clog2(word_size + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STARTING  = 2'd1,
      RECEIVING = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        samp_cnt_q, samp_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [word_size-1:0] shift_q, shift_d;
   logic [word_size-1:0] data_q, data_d;
   logic                 ready_q, ready_d;
   logic                 err1_q, err1_d;
   logic                 err2_q, err2_d;

   // Next-state, counter, shift and host-flag logic.
   always_comb begin
      state_d    = state_q;
      samp_cnt_d = samp_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      ready_d    = ready_q;
      err1_d     = err1_q;
      err2_d     = err2_q;

      // Host read clears the flags; a frame completing on the same edge
      // overrides this below.
      if (Read_ack) begin
         ready_d = 1'b0;
         err1_d  = 1'b0;
         err2_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!Serial_in) begin
               state_d    = STARTING;
               samp_cnt_d = SW'(1);
            end
         end

         STARTING: begin
            if (Serial_in) begin
               // Low pulse shorter than half a bit: treat as a glitch.
               state_d    = IDLE;
               samp_cnt_d = '0;
            end else if (samp_cnt_q == SW'(Half_word - 1)) begin
               state_d    = RECEIVING;
               samp_cnt_d = '0;
               bit_cnt_d  = '0;
            end else begin
               samp_cnt_d = samp_cnt_q + SW'(1);
            end
         end

         RECEIVING: begin
            if (samp_cnt_q == SW'(Samples_per_bit - 1)) begin
               samp_cnt_d = '0;
               if (bit_cnt_q == BW'(word_size)) begin
                  // Stop-bit centre: deliver the word even if framing fails.
                  data_d    = shift_q;
                  ready_d   = 1'b1;
                  err2_d    = err2_d | ~Serial_in;
                  if (ready_q && !Read_ack) begin
                     err1_d = 1'b1;
                  end
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  shift_d   = {Serial_in, shift_q[word_size-1:1]};
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               samp_cnt_d = samp_cnt_q + SW'(1);
            end
         end

         default: begin
            state_d    = IDLE;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase
   end

   // State and output registers; reset takes effect immediately, mid-frame too.
   always_ff @(posedge Clock or negedge rst_b) begin
      if (!rst_b) begin
         state_q    <= IDLE;
         samp_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         ready_q    <= 1'b0;
         err1_q     <= 1'b0;
         err2_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         samp_cnt_q <= samp_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         err1_q     <= err1_d;
         err2_q     <= err2_d;
      end
   end

   assign RCV_datareg = data_q;
   assign Data_ready  = ready_q;
   assign Error1      = err1_q;
   assign Error2      = err2_q;

endmodule

// File: tb/tb_uart_rcvr.sv
// Directed bench for uart_rcvr: frames driven bit by bit, outputs checked
// one time unit after the relevant rising edge.
module tb_uart_rcvr;

   logic       clock;
   logic       rst_b;
   logic       serial_in;
   logic       read_ack;
   logic [7:0] rcv_datareg;
   logic       data_ready;
   logic       error1;
   logic       error2;

   int n_checks = 0;
   int n_fail   = 0;

   uart_rcvr #(
      .word_size      (8),
      .Samples_per_bit(8),
      .Half_word      (4)
   ) dut (
      .Clock      (clock),
      .rst_b      (rst_b),
      .Serial_in  (serial_in),
      .Read_ack   (read_ack),
      .RCV_datareg(rcv_datareg),
      .Data_ready (data_ready),
      .Error1     (error1),
      .Error2     (error2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called 1 time unit after a rising edge. Start bit low from edge 0,
   // data bit i over edges 8(i+1)..8(i+1)+7, stop value over edges 72..75.
   // Returns 1 time unit after edge 75 (stop sample), line still at stop value.
   task automatic send_frame(input logic [7:0] data, input logic stop, input logic ack_on_stop);
      serial_in = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      for (int i = 0; i < 8; i++) begin
         serial_in = data[i];
         repeat (8) @(posedge clock);
         #1;
      end
      serial_in = stop;
      repeat (3) @(posedge clock);
      #1;
      read_ack = ack_on_stop;
      @(posedge clock);
      #1;
      read_ack = 1'b0;
   endtask

   task automatic idle_tail(input int n);
      serial_in = 1'b1;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic ack_pulse();
      read_ack = 1'b1;
      @(posedge clock);
      #1;
      read_ack = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d, input logic rdy,
                          input logic e1, input logic e2);
      chk({tag, ".data"},  {24'h0, rcv_datareg}, {24'h0, d});
      chk({tag, ".ready"}, {31'h0, data_ready},  {31'h0, rdy});
      chk({tag, ".err1"},  {31'h0, error1},      {31'h0, e1});
      chk({tag, ".err2"},  {31'h0, error2},      {31'h0, e2});
   endtask

   initial begin
      rst_b     = 1'b0;
      serial_in = 1'b1;
      read_ack  = 1'b0;

      // 1: reset held with a toggling line
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         serial_in = ~serial_in;
      end
      chk_out("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
      serial_in = 1'b1;
      @(posedge clock);
      #1;
      rst_b = 1'b1;
      idle_tail(20);
      chk_out("rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);

      // 2: clean frame 8'hA5, then host read
      send_frame(8'hA5, 1'b1, 1'b0);
      chk_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
      idle_tail(4);
      ack_pulse();
      chk_out("a5_ack", 8'hA5, 1'b0, 1'b0, 1'b0);

      // 3: two-edge low glitch is rejected, then a real 8'h0F frame
      serial_in = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      idle_tail(90);
      chk("glitch.ready", {31'h0, data_ready}, 32'h0);
      send_frame(8'h0F, 1'b1, 1'b0);
      chk_out("0f", 8'h0F, 1'b1, 1'b0, 1'b0);
      idle_tail(4);
      ack_pulse();

      // 4: framing error, word still delivered
      send_frame(8'h3C, 1'b0, 1'b0);
      chk_out("3c_ferr", 8'h3C, 1'b1, 1'b0, 1'b1);
      idle_tail(4);
      chk("3c_sticky.err2", {31'h0, error2}, 32'h1);
      ack_pulse();
      chk_out("3c_ack", 8'h3C, 1'b0, 1'b0, 1'b0);

      // 5a: overrun without a read
      send_frame(8'h11, 1'b1, 1'b0);
      chk_out("11", 8'h11, 1'b1, 1'b0, 1'b0);
      idle_tail(4);
      send_frame(8'h22, 1'b1, 1'b0);
      chk_out("22_ovr", 8'h22, 1'b1, 1'b1, 1'b0);
      idle_tail(4);
      ack_pulse();
      chk_out("22_ack", 8'h22, 1'b0, 1'b0, 1'b0);

      // 5b: read coinciding with the second stop edge -> completion wins
      send_frame(8'h11, 1'b1, 1'b0);
      idle_tail(4);
      send_frame(8'h22, 1'b1, 1'b1);
      chk_out("22_ackstop", 8'h22, 1'b1, 1'b0, 1'b0);
      idle_tail(4);

      // 6: reset mid-frame (after edge 39) with an unread word pending
      send_frame(8'h77, 1'b1, 1'b0);
      chk("77_ovr.err1", {31'h0, error1}, 32'h1);
      idle_tail(4);
      serial_in = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         serial_in = i[0];
         repeat (8) @(posedge clock);
         #1;
      end
      rst_b = 1'b0;
      #1;
      chk_out("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
      serial_in = 1'b1;
      @(posedge clock);
      #1;
      rst_b = 1'b1;
      idle_tail(10);
      chk_out("midrst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b0);
      chk_out("5a", 8'h5A, 1'b1, 1'b0, 1'b0);
      idle_tail(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
